// File: rtl/ctx_reg_file.sv
// ctx_reg_file: parameterised register file with clear/load/dec/inc
// commands on an active bank, two registered read ports with zero flags,
// and a shadow bank. A serial save/restore engine copies one register per
// cycle between the two banks.
module ctx_reg_file #(
  parameter int W   = 8,
  parameter int N   = 8,
  parameter int SAT = 0,
  localparam int L  = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] I,
  input  logic [1:0]   FunSel,
  input  logic [N-1:0] RSel,
  input  logic [L-1:0] O1Sel,
  input  logic [L-1:0] O2Sel,
  output logic [W-1:0] O1,
  output logic [W-1:0] O2,
  output logic         O1_Z,
  output logic         O2_Z,
  input  logic [1:0]   ctx_cmd,
  input  logic         ctx_start,
  output logic         ctx_busy,
  output logic         ctx_done
);

  localparam bit           SAT_EN = (SAT != 0);
  localparam logic [L-1:0] K_LAST = L'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_COPY = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t       state_reg, state_next;
  logic [L-1:0] k_reg, k_next;
  logic         restore_reg, restore_next;

  // Register commands are honoured whenever the copy engine is not walking
  // the banks; DONE behaves like IDLE for both commands and new starts.
  logic ops_en;
  logic start_ok;

  assign ops_en   = (state_reg != ST_COPY);
  assign start_ok = ops_en && ctx_start && (ctx_cmd[0] ^ ctx_cmd[1]);

  // Next value of every active register, packed so the read ports can pick
  // the post-edge value (write-through).
  logic [N-1:0][W-1:0] r_next_all;

  // FSM state, copy index and latched direction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      k_reg       <= '0;
      restore_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      k_reg       <= k_next;
      restore_reg <= restore_next;
    end
  end

  // Next-state logic: accept a start from IDLE/DONE, walk k across the banks.
  always_comb begin
    state_next   = state_reg;
    k_next       = k_reg;
    restore_next = restore_reg;
    case (state_reg)
      ST_COPY: begin
        k_next = k_reg + 1'b1;
        if (k_reg == K_LAST) begin
          state_next = ST_DONE;
        end
      end
      default: begin
        if (start_ok) begin
          state_next   = ST_COPY;
          k_next       = '0;
          restore_next = ctx_cmd[1];
        end else begin
          state_next = ST_IDLE;
        end
      end
    endcase
  end

  assign ctx_busy = (state_reg == ST_COPY);
  assign ctx_done = (state_reg == ST_DONE);

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_reg
      localparam logic [L-1:0] IDX = L'(gi);

      logic [W-1:0] r_reg, r_next;
      logic [W-1:0] s_reg, s_next;
      logic         copy_hit;

      assign copy_hit = (state_reg == ST_COPY) && (k_reg == IDX);

      // Active register: command update, or restore from shadow on its copy slot.
      always_comb begin
        r_next = r_reg;
        if (ops_en && RSel[gi]) begin
          case (FunSel)
            2'b00: r_next = '0;
            2'b01: r_next = I;
            2'b10: begin
              if (SAT_EN && (r_reg == '0)) r_next = r_reg;
              else                         r_next = r_reg - 1'b1;
            end
            default: begin
              if (SAT_EN && (r_reg == '1)) r_next = r_reg;
              else                         r_next = r_reg + 1'b1;
            end
          endcase
        end else if (copy_hit && restore_reg) begin
          r_next = s_reg;
        end
      end

      // Shadow register: only written on its save slot.
      always_comb begin
        s_next = s_reg;
        if (copy_hit && !restore_reg) begin
          s_next = r_reg;
        end
      end

      // Bank storage; reset wipes both banks so no partial copy survives.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_reg <= '0;
          s_reg <= '0;
        end else begin
          r_reg <= r_next;
          s_reg <= s_next;
        end
      end

      assign r_next_all[gi] = r_next;
    end
  endgenerate

  logic [W-1:0] o1_reg, o2_reg;
  logic         o1_z_reg, o2_z_reg;

  // Registered read ports with zero flags, fed from post-update values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o1_reg   <= '0;
      o2_reg   <= '0;
      o1_z_reg <= 1'b1;
      o2_z_reg <= 1'b1;
    end else begin
      o1_reg   <= r_next_all[O1Sel];
      o2_reg   <= r_next_all[O2Sel];
      o1_z_reg <= (r_next_all[O1Sel] == '0);
      o2_z_reg <= (r_next_all[O2Sel] == '0);
    end
  end

  assign O1   = o1_reg;
  assign O2   = o2_reg;
  assign O1_Z = o1_z_reg;
  assign O2_Z = o2_z_reg;

endmodule

// File: tb/tb_ctx_reg_file.sv
// Bench for ctx_reg_file: a wrapping and a saturating instance share all
// inputs; a per-edge behavioural model of both banks predicts every output.
module tb_ctx_reg_file;

  localparam int W = 8;
  localparam int N = 8;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] I;
  logic [1:0]   FunSel;
  logic [N-1:0] RSel;
  logic [2:0]   O1Sel, O2Sel;
  logic [1:0]   ctx_cmd;
  logic         ctx_start;

  logic [W-1:0] o1_q   [2];
  logic [W-1:0] o2_q   [2];
  logic         o1z_q  [2];
  logic         o2z_q  [2];
  logic         busy_q [2];
  logic         done_q [2];

  ctx_reg_file #(.W(W), .N(N), .SAT(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .I(I), .FunSel(FunSel), .RSel(RSel),
    .O1Sel(O1Sel), .O2Sel(O2Sel), .O1(o1_q[0]), .O2(o2_q[0]),
    .O1_Z(o1z_q[0]), .O2_Z(o2z_q[0]), .ctx_cmd(ctx_cmd),
    .ctx_start(ctx_start), .ctx_busy(busy_q[0]), .ctx_done(done_q[0])
  );

  ctx_reg_file #(.W(W), .N(N), .SAT(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .I(I), .FunSel(FunSel), .RSel(RSel),
    .O1Sel(O1Sel), .O2Sel(O2Sel), .O1(o1_q[1]), .O2(o2_q[1]),
    .O1_Z(o1z_q[1]), .O2_Z(o2z_q[1]), .ctx_cmd(ctx_cmd),
    .ctx_start(ctx_start), .ctx_busy(busy_q[1]), .ctx_done(done_q[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: index 0 = wrapping instance, 1 = saturating instance.
  int       mr [2][N];
  int       ms [2][N];
  int       edge_no    = 0;
  int       start_edge = -1000;
  bit       m_restore  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < 2; j++)
      for (int i = 0; i < N; i++) begin
        mr[j][i] = 0;
        ms[j][i] = 0;
      end
    start_edge = -1000;
    m_restore  = 1'b0;
  endtask

  task automatic check_reset_outputs(input string where);
    for (int j = 0; j < 2; j++) begin
      check($sformatf("%s_o1_sat%0d", where, j), o1_q[j], 0);
      check($sformatf("%s_o2_sat%0d", where, j), o2_q[j], 0);
      check($sformatf("%s_o1z_sat%0d", where, j), o1z_q[j], 1);
      check($sformatf("%s_o2z_sat%0d", where, j), o2z_q[j], 1);
      check($sformatf("%s_busy_sat%0d", where, j), busy_q[j], 0);
      check($sformatf("%s_done_sat%0d", where, j), done_q[j], 0);
    end
  endtask

  // One clock edge: advance the model with the current inputs, then compare.
  task automatic tick();
    bit in_copy;
    int v, k, e1, e2;
    bit exp_busy, exp_done;
    edge_no++;
    in_copy = (edge_no >= start_edge + 1) && (edge_no <= start_edge + N);
    for (int j = 0; j < 2; j++) begin
      if (in_copy) begin
        k = edge_no - start_edge - 1;
        if (m_restore) mr[j][k] = ms[j][k];
        else           ms[j][k] = mr[j][k];
      end else begin
        for (int i = 0; i < N; i++) begin
          if (RSel[i]) begin
            v = mr[j][i];
            case (FunSel)
              2'd0: v = 0;
              2'd1: v = int'(I);
              2'd2: begin v = v - 1; if (v < 0)   v = (j == 1) ? 0 : 255; end
              default: begin v = v + 1; if (v > 255) v = (j == 1) ? 255 : 0; end
            endcase
            mr[j][i] = v;
          end
        end
      end
    end
    if (!in_copy && ctx_start && (ctx_cmd == 2'b01 || ctx_cmd == 2'b10)) begin
      start_edge = edge_no;
      m_restore  = (ctx_cmd == 2'b10);
    end
    @(posedge clk);
    #1;
    exp_busy = (edge_no >= start_edge) && (edge_no < start_edge + N);
    exp_done = (edge_no == start_edge + N);
    for (int j = 0; j < 2; j++) begin
      e1 = mr[j][O1Sel];
      e2 = mr[j][O2Sel];
      check($sformatf("o1_sat%0d_e%0d", j, edge_no), o1_q[j], e1);
      check($sformatf("o2_sat%0d_e%0d", j, edge_no), o2_q[j], e2);
      check($sformatf("o1z_sat%0d_e%0d", j, edge_no), o1z_q[j], (e1 == 0));
      check($sformatf("o2z_sat%0d_e%0d", j, edge_no), o2z_q[j], (e2 == 0));
      check($sformatf("busy_sat%0d_e%0d", j, edge_no), busy_q[j], exp_busy);
      check($sformatf("done_sat%0d_e%0d", j, edge_no), done_q[j], exp_done);
    end
  endtask

  task automatic scan();
    RSel      = '0;
    ctx_start = 1'b0;
    for (int i = 0; i < N; i++) begin
      O1Sel = 3'(i);
      O2Sel = 3'(N - 1 - i);
      tick();
    end
  endtask

  initial begin
    int busy_cnt, done_cnt;

    // Reset
    rst_n = 1'b0; I = '0; FunSel = 2'b00; RSel = '0;
    O1Sel = '0; O2Sel = '0; ctx_cmd = 2'b00; ctx_start = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Load 5A into R7 and R0, read both back, then confirm R1..R6 still zero
    FunSel = 2'b01; I = 8'h5A; RSel = 8'h81; O1Sel = 3'd7; O2Sel = 3'd0;
    tick();
    scan();

    // Wrap vs saturate on R2: increment from FF, decrement from 00
    O1Sel = 3'd2; O2Sel = 3'd2;
    FunSel = 2'b01; I = 8'hFF; RSel = 8'h04; tick();
    FunSel = 2'b11; tick();
    FunSel = 2'b01; I = 8'h00; tick();
    FunSel = 2'b10; tick();

    // Load R[i] = i+1
    for (int i = 0; i < N; i++) begin
      FunSel = 2'b01; I = 8'(i + 1); RSel = 8'(1 << i); O1Sel = 3'(i);
      tick();
    end

    // Save; writes are attempted during the copy and a second start arrives
    // on the 3rd busy cycle.
    RSel = '0; ctx_cmd = 2'b01; ctx_start = 1'b1;
    busy_cnt = 0; done_cnt = 0;
    tick();
    busy_cnt += int'(busy_q[0]); done_cnt += int'(done_q[0]);
    FunSel = 2'b11; RSel = 8'hFF;
    for (int t = 0; t < 11; t++) begin
      ctx_start = (t == 2);
      O1Sel = 3'(t % N);
      tick();
      busy_cnt += int'(busy_q[0]); done_cnt += int'(done_q[0]);
    end
    check("save_busy_cycles", busy_cnt, N);
    check("save_done_pulses", done_cnt, 1);

    // Ignored start in IDLE (cmd 11)
    RSel = '0; ctx_cmd = 2'b11; ctx_start = 1'b1;
    tick();
    ctx_start = 1'b0;
    tick();

    // Clear all, then restore while reading each slot as it is copied
    FunSel = 2'b00; RSel = 8'hFF; tick();
    RSel = '0; ctx_cmd = 2'b10; ctx_start = 1'b1; tick();
    ctx_start = 1'b0;
    for (int k = 0; k < N; k++) begin
      O1Sel = 3'(k); O2Sel = 3'(N - 1 - k);
      tick();
    end
    tick();
    scan();

    // Randomised traffic with occasional context commands
    for (int t = 0; t < 300; t++) begin
      I         = 8'($urandom);
      FunSel    = 2'($urandom_range(0, 3));
      RSel      = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      O1Sel     = 3'($urandom_range(0, 7));
      O2Sel     = 3'($urandom_range(0, 7));
      ctx_cmd   = 2'($urandom_range(0, 3));
      ctx_start = ($urandom_range(0, 15) == 0);
      tick();
    end

    // Save known content, clear, then reset on the 4th restore cycle
    ctx_start = 1'b0; FunSel = 2'b01; I = 8'h3C; RSel = 8'hFF; tick();
    RSel = '0; ctx_cmd = 2'b01; ctx_start = 1'b1; tick();
    ctx_start = 1'b0;
    repeat (N + 1) tick();
    FunSel = 2'b00; RSel = 8'hFF; tick();
    RSel = '0; O1Sel = 3'd0; O2Sel = 3'd1; ctx_cmd = 2'b10; ctx_start = 1'b1; tick();
    ctx_start = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    #2;
    model_reset();
    check_reset_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Restore after reset yields zeros
    ctx_cmd = 2'b10; ctx_start = 1'b1; tick();
    ctx_start = 1'b0;
    repeat (N + 1) tick();
    scan();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
